// File: rtl/jpeg_huff_pkg.sv
// Shared state encoding, component ids and block geometry for the JPEG Huffman scheduler.
package jpeg_huff_pkg;

  typedef enum logic [2:0] {IDLE, START, RUN, DRAIN, RELEASE, RST} state_t;

  localparam logic [1:0] COMP_Y  = 2'd0;
  localparam logic [1:0] COMP_CB = 2'd1;
  localparam logic [1:0] COMP_CR = 2'd2;

  localparam int BLOCK_COEFFS = 64;

  // MCU layout is LUMA_BLOCKS luma blocks followed by one Cb and one Cr block.
  function automatic logic [1:0] comp_for_block(input logic [2:0] blk, input int luma_blocks);
    if (int'(blk) < luma_blocks) return COMP_Y;
    else if (int'(blk) == luma_blocks) return COMP_CB;
    else return COMP_CR;
  endfunction

endpackage

// File: rtl/jpeg_rr_arbiter.sv
// Combinational round-robin pick: the first requesting bank at or after ptr, wrapping.
module jpeg_rr_arbiter #(
  parameter int NUM_BANKS = 2,
  parameter int SEL_W     = 1
) (
  input  logic [NUM_BANKS-1:0] req,
  input  logic [SEL_W-1:0]     ptr,
  output logic [SEL_W-1:0]     grant,
  output logic                 valid
);

  // Walk offsets from farthest to nearest so the bank closest to ptr wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      for (int j = 0; j < NUM_BANKS; j++) begin
        if (req[j] && (((int'(ptr) + i >= NUM_BANKS) ? (int'(ptr) + i - NUM_BANKS)
                                                      : (int'(ptr) + i)) == j)) begin
          grant = SEL_W'(j);
          valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/jpeg_huffman_scheduler.sv
// Schedules jpeg_huffman_encode over ping-pong coefficient banks and tracks the MCU component pattern.
// Restart-interval handling (RST state, rst_req/rst_ack) is built only with `define JPEG_HUFF_RESTART_EN.
module jpeg_huffman_scheduler #(
  parameter int NUM_BANKS    = 2,
  parameter int BANK_SEL_W   = 1,
  parameter int BLOCK_COEFFS = jpeg_huff_pkg::BLOCK_COEFFS,
  parameter int DRAIN_CYCLES = 4,
  parameter int LUMA_BLOCKS  = 4,
  parameter int RESTART_MCUS = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [NUM_BANKS-1:0]  bank_full,
  output logic [NUM_BANKS-1:0]  bank_release,
  output logic [BANK_SEL_W-1:0] bank_sel,
  output logic                  huff_start,
  output logic                  huff_stall,
  input  logic                  downstream_stall,
  output logic [1:0]            comp_id,
  output logic                  dc_pred_clear,
  output logic                  busy,
  output logic                  rst_req,
  input  logic                  rst_ack
);
  import jpeg_huff_pkg::*;

  localparam int CW = $clog2(BLOCK_COEFFS);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0]         COEFF_LAST = CW'(BLOCK_COEFFS - 1);
  localparam logic [DW-1:0]         DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [2:0]            BLK_LAST   = 3'(LUMA_BLOCKS + 1);
  localparam logic [BANK_SEL_W-1:0] SEL_LAST   = BANK_SEL_W'(NUM_BANKS - 1);

  state_t                state_q, state_d;
  logic [BANK_SEL_W-1:0] rr_ptr, grant_idx;
  logic                  grant_valid, grant_take, frame_now;
  logic                  frame_pending, frame_apply, mcu_done;
  logic [2:0]            blk_in_mcu;
  logic [CW-1:0]         coeff_cnt;
  logic [DW-1:0]         drain_cnt;

  assign huff_stall  = downstream_stall;
  assign busy        = (state_q != IDLE);
  assign frame_apply = frame_pending | frame_start;
  assign mcu_done    = (blk_in_mcu == BLK_LAST);

`ifdef JPEG_HUFF_RESTART_EN
  localparam int MW = $clog2(RESTART_MCUS + 1);
  localparam logic [MW-1:0] MCU_LAST = MW'(RESTART_MCUS - 1);
  logic [MW-1:0] mcu_cnt;
  logic          restart_due;
  // A pending frame start supersedes the restart marker: the new frame resets everything anyway.
  assign restart_due = mcu_done && (mcu_cnt == MCU_LAST) && !frame_apply;
`else
  logic unused_rst_ack;
  localparam int unused_restart_mcus = RESTART_MCUS;
  assign unused_rst_ack = rst_ack;
  assign rst_req        = 1'b0;
`endif

  jpeg_rr_arbiter #(.NUM_BANKS(NUM_BANKS), .SEL_W(BANK_SEL_W)) u_arb (
    .req  (bank_full),
    .ptr  (rr_ptr),
    .grant(grant_idx),
    .valid(grant_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A frame start seen in IDLE costs one cycle so the DC clear lands ahead of the next huff_start.
  always_comb begin
    state_d      = state_q;
    huff_start   = 1'b0;
    bank_release = '0;
    grant_take   = 1'b0;
    frame_now    = 1'b0;
`ifdef JPEG_HUFF_RESTART_EN
    rst_req      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          frame_now = 1'b1;
        end else if (grant_valid) begin
          grant_take = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        huff_start = 1'b1;
        state_d    = RUN;
      end
      RUN:   if (!downstream_stall && coeff_cnt == COEFF_LAST) state_d = DRAIN;
      DRAIN: if (!downstream_stall && drain_cnt == DRAIN_LAST) state_d = RELEASE;
      RELEASE: begin
        bank_release = NUM_BANKS'(1) << bank_sel;
        state_d      = IDLE;
`ifdef JPEG_HUFF_RESTART_EN
        if (restart_due) state_d = RST;
`endif
      end
`ifdef JPEG_HUFF_RESTART_EN
      RST: begin
        rst_req = 1'b1;
        if (rst_ack) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Frame starts arriving mid-block are parked and applied once the block has been released.
  always_ff @(posedge clock) begin
    if (reset) begin
      bank_sel      <= '0;
      comp_id       <= COMP_Y;
      rr_ptr        <= '0;
      blk_in_mcu    <= '0;
      coeff_cnt     <= '0;
      drain_cnt     <= '0;
      frame_pending <= 1'b0;
      dc_pred_clear <= 1'b0;
`ifdef JPEG_HUFF_RESTART_EN
      mcu_cnt       <= '0;
`endif
    end else begin
      dc_pred_clear <= 1'b0;
      if (busy && frame_start) frame_pending <= 1'b1;
      case (state_q)
        IDLE: begin
          if (frame_now) begin
            blk_in_mcu    <= '0;
            dc_pred_clear <= 1'b1;
`ifdef JPEG_HUFF_RESTART_EN
            mcu_cnt       <= '0;
`endif
          end else if (grant_take) begin
            bank_sel <= grant_idx;
            comp_id  <= comp_for_block(blk_in_mcu, LUMA_BLOCKS);
          end
        end
        START: coeff_cnt <= '0;
        RUN: begin
          if (!downstream_stall) begin
            coeff_cnt <= coeff_cnt + CW'(1);
            drain_cnt <= '0;
          end
        end
        DRAIN: if (!downstream_stall) drain_cnt <= drain_cnt + DW'(1);
        RELEASE: begin
          rr_ptr <= (bank_sel == SEL_LAST) ? '0 : bank_sel + BANK_SEL_W'(1);
          if (frame_apply) begin
            blk_in_mcu    <= '0;
            dc_pred_clear <= 1'b1;
            frame_pending <= 1'b0;
`ifdef JPEG_HUFF_RESTART_EN
            mcu_cnt       <= '0;
`endif
          end else begin
            blk_in_mcu <= mcu_done ? 3'd0 : blk_in_mcu + 3'd1;
`ifdef JPEG_HUFF_RESTART_EN
            if (mcu_done && !restart_due) mcu_cnt <= mcu_cnt + MW'(1);
`endif
          end
        end
`ifdef JPEG_HUFF_RESTART_EN
        RST: begin
          if (rst_ack) begin
            dc_pred_clear <= 1'b1;
            mcu_cnt       <= '0;
            if (frame_apply) begin
              blk_in_mcu    <= '0;
              frame_pending <= 1'b0;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_huffman_scheduler.sv
// Directed, table-driven bench for jpeg_huffman_scheduler (NUM_BANKS=2, LUMA_BLOCKS=4, DRAIN_CYCLES=4).
// With JPEG_HUFF_RESTART_EN defined a second instance (LUMA_BLOCKS=1, RESTART_MCUS=1) covers restart markers.
module tb_jpeg_huffman_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       downstream_stall = 1'b0;
  logic       rst_ack = 1'b0;
  logic [1:0] bank_full = 2'b00;
  logic [1:0] bank_release;
  logic [0:0] bank_sel;
  logic       huff_start, huff_stall, dc_pred_clear, busy, rst_req;
  logic [1:0] comp_id;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] full;
    int         exp_sel;
    int         exp_comp;
  } vec_t;

  vec_t tbl[10];

  always #5 clock = ~clock;

  jpeg_huffman_scheduler #(
    .NUM_BANKS(2), .BANK_SEL_W(1), .BLOCK_COEFFS(64), .DRAIN_CYCLES(4), .LUMA_BLOCKS(4), .RESTART_MCUS(16)
  ) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .bank_full(bank_full),
    .bank_release(bank_release), .bank_sel(bank_sel), .huff_start(huff_start), .huff_stall(huff_stall),
    .downstream_stall(downstream_stall), .comp_id(comp_id), .dc_pred_clear(dc_pred_clear),
    .busy(busy), .rst_req(rst_req), .rst_ack(rst_ack)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] full, input logic fs, input logic stall);
    bank_full        = full;
    frame_start      = fs;
    downstream_stall = stall;
    #1;
  endtask

  task automatic doReset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic waitHuffStart(input string name, output int cycles);
    cycles = 0;
    while (!huff_start && cycles < 20) begin
      tick();
      cycles++;
    end
    if (!huff_start) checkOutput({name, " start timeout"}, 0, 1);
  endtask

  // Counts cycles inclusively from the huff_start cycle (occ_in) up to the release cycle.
  task automatic waitRelease(input string name, input int occ_in, output int occ, output int dc_seen);
    occ = occ_in;
    dc_seen = 0;
    while (bank_release == 2'b00 && occ < 300) begin
      tick();
      occ++;
      if (dc_pred_clear) dc_seen++;
    end
    if (bank_release == 2'b00) checkOutput({name, " release timeout"}, 0, 1);
  endtask

`ifdef JPEG_HUFF_RESTART_EN
  logic [1:0] r_full = 2'b00;
  logic       r_frame = 1'b0;
  logic       r_stall = 1'b0;
  logic       r_ack = 1'b0;
  logic [1:0] r_release;
  logic [0:0] r_sel;
  logic       r_huff_start, r_huff_stall, r_dc, r_busy, r_rst_req;
  logic [1:0] r_comp;

  jpeg_huffman_scheduler #(
    .NUM_BANKS(2), .BANK_SEL_W(1), .BLOCK_COEFFS(64), .DRAIN_CYCLES(4), .LUMA_BLOCKS(1), .RESTART_MCUS(1)
  ) dut_rst (
    .clock(clock), .reset(reset), .frame_start(r_frame), .bank_full(r_full),
    .bank_release(r_release), .bank_sel(r_sel), .huff_start(r_huff_start), .huff_stall(r_huff_stall),
    .downstream_stall(r_stall), .comp_id(r_comp), .dc_pred_clear(r_dc),
    .busy(r_busy), .rst_req(r_rst_req), .rst_ack(r_ack)
  );

  task automatic runRestartTest;
    int cnt, starts, drops;
    doReset();
    r_full = 2'b01;
    for (int b = 0; b < 3; b++) begin
      cnt = 0;
      while (!r_huff_start && cnt < 20) begin tick(); cnt++; end
      checkOutput("t6 huff_start seen", r_huff_start, 1);
      checkOutput("t6 comp_id", r_comp, b);
      cnt = 0;
      while (r_release == 2'b00 && cnt < 300) begin tick(); cnt++; end
      checkOutput("t6 release", r_release, 2'b01);
    end
    tick();
    checkOutput("t6 rst_req rises", r_rst_req, 1);
    starts = 0;
    drops = 0;
    repeat (5) begin
      tick();
      if (r_huff_start) starts++;
      if (!r_rst_req) drops++;
    end
    checkOutput("t6 no huff_start in RST", starts, 0);
    checkOutput("t6 rst_req held", drops, 0);
    r_ack = 1'b1;
    tick();
    r_ack = 1'b0;
    checkOutput("t6 dc_pred_clear after ack", r_dc, 1);
    checkOutput("t6 rst_req drops", r_rst_req, 0);
    tick();
    checkOutput("t6 resume huff_start", r_huff_start, 1);
    checkOutput("t6 resume comp_id", r_comp, 0);
    r_full = 2'b00;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc, occ, dcs;

    tbl[0] = '{2'b11, 0, 0};
    tbl[1] = '{2'b11, 1, 0};
    tbl[2] = '{2'b11, 0, 0};
    tbl[3] = '{2'b11, 1, 0};
    tbl[4] = '{2'b11, 0, 1};
    tbl[5] = '{2'b11, 1, 2};
    tbl[6] = '{2'b11, 0, 0};
    tbl[7] = '{2'b01, 0, 0};
    tbl[8] = '{2'b10, 1, 0};
    tbl[9] = '{2'b11, 0, 0};

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    checkOutput("reset busy", busy, 0);
    checkOutput("reset huff_start", huff_start, 0);
    checkOutput("reset bank_release", bank_release, 0);
    checkOutput("reset bank_sel", bank_sel, 0);
    checkOutput("reset comp_id", comp_id, 0);
    checkOutput("reset dc_pred_clear", dc_pred_clear, 0);
    checkOutput("reset rst_req", rst_req, 0);
    reset = 1'b0;

    // Single bank: bank_full cycle then START cycle; occupancy START..RELEASE is 70 cycles
    applyStimulus(2'b01, 1'b0, 1'b0);
    checkOutput("t1 idle huff_start", huff_start, 0);
    waitHuffStart("t1", cyc);
    checkOutput("t1 latency edges", cyc, 1);
    checkOutput("t1 bank_sel", bank_sel, 0);
    checkOutput("t1 comp_id", comp_id, 0);
    checkOutput("t1 busy", busy, 1);
    waitRelease("t1", 1, occ, dcs);
    checkOutput("t1 occupancy", occ, 70);
    checkOutput("t1 bank_release", bank_release, 2'b01);
    applyStimulus(2'b00, 1'b0, 1'b0);
    tick();
    checkOutput("t1 idle busy", busy, 0);
    checkOutput("t1 release one cycle", bank_release, 0);

    // Both banks full: alternating grants and Y Y Y Y Cb Cr component pattern
    doReset();
    for (int r = 0; r < 10; r++) begin
      applyStimulus(tbl[r].full, 1'b0, 1'b0);
      waitHuffStart("t2", cyc);
      checkOutput($sformatf("t2 row%0d bank_sel", r), bank_sel, tbl[r].exp_sel);
      checkOutput($sformatf("t2 row%0d comp_id", r), comp_id, tbl[r].exp_comp);
      waitRelease("t2", 1, occ, dcs);
      checkOutput($sformatf("t2 row%0d occupancy", r), occ, 70);
      checkOutput($sformatf("t2 row%0d release", r), bank_release, 32'd1 << tbl[r].exp_sel);
    end
    applyStimulus(2'b00, 1'b0, 1'b0);
    tick();

    // Ten stalled cycles starting at coeff_cnt=30 stretch occupancy to 80
    doReset();
    applyStimulus(2'b01, 1'b0, 1'b0);
    waitHuffStart("t3", cyc);
    occ = 1;
    repeat (31) begin tick(); occ++; end
    checkOutput("t3 huff_stall low", huff_stall, 0);
    applyStimulus(2'b01, 1'b0, 1'b1);
    checkOutput("t3 huff_stall mirrors", huff_stall, 1);
    repeat (10) begin tick(); occ++; end
    applyStimulus(2'b01, 1'b0, 1'b0);
    checkOutput("t3 huff_stall released", huff_stall, 0);
    waitRelease("t3", occ, occ, dcs);
    checkOutput("t3 stalled occupancy", occ, 80);
    applyStimulus(2'b00, 1'b0, 1'b0);
    tick();

    // Frame start during the Cb block: block finishes, clear follows release, next block is Y
    doReset();
    applyStimulus(2'b01, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      waitHuffStart("t4 pre", cyc);
      waitRelease("t4 pre", 1, occ, dcs);
    end
    waitHuffStart("t4", cyc);
    checkOutput("t4 comp_id Cb", comp_id, 1);
    occ = 1;
    repeat (21) begin tick(); occ++; end
    applyStimulus(2'b01, 1'b1, 1'b0);
    tick();
    occ++;
    applyStimulus(2'b01, 1'b0, 1'b0);
    checkOutput("t4 no early clear", dc_pred_clear, 0);
    checkOutput("t4 comp_id held", comp_id, 1);
    waitRelease("t4", occ, occ, dcs);
    checkOutput("t4 occupancy", occ, 70);
    checkOutput("t4 no clear in block", dcs, 0);
    tick();
    checkOutput("t4 dc_pred_clear after release", dc_pred_clear, 1);
    checkOutput("t4 idle", busy, 0);
    tick();
    checkOutput("t4 next huff_start", huff_start, 1);
    checkOutput("t4 next comp_id", comp_id, 0);
    applyStimulus(2'b00, 1'b0, 1'b0);

    // Reset during DRAIN: outputs clear, no release, fresh grant restarts at bank 0
    doReset();
    applyStimulus(2'b11, 1'b0, 1'b0);
    waitHuffStart("t5", cyc);
    repeat (66) tick();
    checkOutput("t5 busy in drain", busy, 1);
    reset = 1'b1;
    tick();
    checkOutput("t5 busy", busy, 0);
    checkOutput("t5 no release", bank_release, 0);
    checkOutput("t5 bank_sel", bank_sel, 0);
    checkOutput("t5 comp_id", comp_id, 0);
    checkOutput("t5 huff_start", huff_start, 0);
    reset = 1'b0;
    tick();
    checkOutput("t5 regrant huff_start", huff_start, 1);
    checkOutput("t5 regrant bank_sel", bank_sel, 0);
    applyStimulus(2'b00, 1'b0, 1'b0);

`ifdef JPEG_HUFF_RESTART_EN
    runRestartTest();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
